// File: rtl/risc_ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: opcodes, instruction classes,
// FSM state encodings and the datapath strobe bundle.
package risc_ctrl_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_RET  = 8'h08;
  localparam logic [7:0] OP_LDI  = 8'h10;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [1:0] CLS_ALU_RR = 2'b01;
  localparam logic [1:0] CLS_ALU_RI = 2'b10;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RDOPS = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WB    = 3'd4,
    ST_POP   = 3'd5,
    ST_LATCH = 3'd6,
    ST_HALT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    IC_NOP     = 3'd0,
    IC_ILLEGAL = 3'd1,
    IC_ALU_RR  = 3'd2,
    IC_ALU_RI  = 3'd3,
    IC_LDI     = 3'd4,
    IC_RET     = 3'd5,
    IC_HALT    = 3'd6
  } iclass_e;

  typedef struct packed {
    logic fetch;
    logic rst_alu;
    logic rd_a;
    logic rd_b;
    logic imm_b;
    logic imm_alu;
    logic wr_en;
    logic pop;
    logic latch;
    logic busy;
    logic halted;
  } strobe_t;

  localparam strobe_t STROBE_NONE = '{default: 1'b0};
  localparam strobe_t STROBE_INIT = '{rst_alu: 1'b1, default: 1'b0};

  // Exact-match opcodes take priority over the two-bit ALU class prefixes.
  function automatic iclass_e decode_op(input logic [7:0] op);
    iclass_e cls;
    cls = IC_ILLEGAL;
    if (op == OP_NOP) begin
      cls = IC_NOP;
    end else if (op == OP_RET) begin
      cls = IC_RET;
    end else if (op == OP_LDI) begin
      cls = IC_LDI;
    end else if (op == OP_HALT) begin
      cls = IC_HALT;
    end else if (op[7:6] == CLS_ALU_RR) begin
      cls = IC_ALU_RR;
    end else if (op[7:6] == CLS_ALU_RI) begin
      cls = IC_ALU_RI;
    end else begin
      cls = IC_ILLEGAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/risc_exec_timer.sv
// Loadable down-counter that times the EXEC phase; zero marks its last cycle.
module risc_exec_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt_r;

  // Count register: load wins over decrement, and the count never wraps below zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r <= 4'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/risc_ctrl_seq.sv
// Multi-cycle control sequencer: decodes one held instruction at a time and
// steps the ALU/register-file datapath through its phases.
module risc_ctrl_seq
  import risc_ctrl_seq_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Instr_Valid,
  input  logic [7:0]       Opcode,
  output logic             Fetch_Req,
  output logic             Reset_AluRegs,
  output logic             Rd_Oprnd_A,
  output logic             Rd_Oprnd_B,
  output logic             UseData_Imm_Or_RegB,
  output logic             UseData_Imm_Or_ALU,
  output logic             Reg_Wr_En,
  output logic             Pop_Psw,
  output logic             Latch_Flags,
  output logic             Busy,
  output logic             Halted,
  output logic             Illegal_Op,
  output logic [CNT_W-1:0] Instr_Count
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  iclass_e           class_r;
  iclass_e           class_nxt_s;
  iclass_e           dec_class_s;
  logic              accept_s;
  logic              retire_s;
  logic              tmr_load_s;
  logic              tmr_dec_s;
  logic              tmr_zero_s;
  strobe_t           strb_s;
  strobe_t           strb_r;
  logic              illegal_r;
  logic [CNT_W-1:0]  count_r;

  assign dec_class_s = decode_op(Opcode);
  assign accept_s    = (state_r == ST_IDLE) && Instr_Valid;
  assign tmr_load_s  = (state_r == ST_RDOPS);
  assign tmr_dec_s   = (state_r == ST_EXEC);

  risc_exec_timer u_exec_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tmr_load_s),
    .load_val (LAT_LOAD),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Next-state, class capture and retire detection.
  always_comb begin
    state_nxt_s = state_r;
    class_nxt_s = class_r;
    retire_s    = 1'b0;
    case (state_r)
      ST_INIT:  state_nxt_s = ST_IDLE;
      ST_IDLE: begin
        if (Instr_Valid) begin
          class_nxt_s = dec_class_s;
          case (dec_class_s)
            IC_ALU_RR, IC_ALU_RI: state_nxt_s = ST_RDOPS;
            IC_LDI:               state_nxt_s = ST_WB;
            IC_RET:               state_nxt_s = ST_POP;
            IC_HALT: begin
              state_nxt_s = ST_HALT;
              retire_s    = 1'b1;
            end
            default: begin
              state_nxt_s = ST_IDLE;
              retire_s    = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RDOPS: state_nxt_s = ST_EXEC;
      ST_EXEC: begin
        if (tmr_zero_s) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_WB: begin
        state_nxt_s = ST_IDLE;
        retire_s    = 1'b1;
      end
      ST_POP:   state_nxt_s = ST_LATCH;
      ST_LATCH: begin
        state_nxt_s = ST_IDLE;
        retire_s    = 1'b1;
      end
      ST_HALT:  state_nxt_s = ST_HALT;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // Strobes decoded from the upcoming state so the registered copy lines up with it.
  always_comb begin
    strb_s = STROBE_NONE;
    case (state_nxt_s)
      ST_INIT:  strb_s.rst_alu = 1'b1;
      ST_IDLE:  strb_s.fetch   = 1'b1;
      ST_RDOPS: begin
        strb_s.rd_a  = 1'b1;
        strb_s.rd_b  = 1'b1;
        strb_s.imm_b = (class_nxt_s == IC_ALU_RI);
        strb_s.busy  = 1'b1;
      end
      ST_EXEC:  strb_s.busy = 1'b1;
      ST_WB: begin
        strb_s.wr_en   = 1'b1;
        strb_s.imm_alu = (class_nxt_s == IC_LDI);
        strb_s.busy    = 1'b1;
      end
      ST_POP: begin
        strb_s.pop  = 1'b1;
        strb_s.busy = 1'b1;
      end
      ST_LATCH: begin
        strb_s.latch = 1'b1;
        strb_s.busy  = 1'b1;
      end
      ST_HALT:  strb_s.halted = 1'b1;
      default:  strb_s = STROBE_NONE;
    endcase
  end

  // State, captured class, output strobes, illegal pulse and retire counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= ST_INIT;
      class_r   <= IC_NOP;
      strb_r    <= STROBE_INIT;
      illegal_r <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      class_r   <= class_nxt_s;
      strb_r    <= strb_s;
      illegal_r <= accept_s && (dec_class_s == IC_ILLEGAL);
      if (retire_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign Fetch_Req           = strb_r.fetch;
  assign Reset_AluRegs       = strb_r.rst_alu;
  assign Rd_Oprnd_A          = strb_r.rd_a;
  assign Rd_Oprnd_B          = strb_r.rd_b;
  assign UseData_Imm_Or_RegB = strb_r.imm_b;
  assign UseData_Imm_Or_ALU  = strb_r.imm_alu;
  assign Reg_Wr_En           = strb_r.wr_en;
  assign Pop_Psw             = strb_r.pop;
  assign Latch_Flags         = strb_r.latch;
  assign Busy                = strb_r.busy;
  assign Halted              = strb_r.halted;
  assign Illegal_Op          = illegal_r;
  assign Instr_Count         = count_r;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Bench for risc_ctrl_seq: two instances (ALU_LAT 1 and 3) checked every cycle
// against a schedule-based model, plus hand-computed latency/count checks.
module tb_risc_ctrl_seq;

  typedef struct packed {
    logic fetch, rst_alu, rda, rdb, immb, immalu, wr, pop, latch, busy, halted, ill;
  } vec_t;
  typedef struct packed {
    vec_t v;
    logic ret;
  } exp_t;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic Clk = 1'b0;
  logic Reset;
  logic       iv[2];
  logic [7:0] op[2];
  logic fetch_req[2], rst_alu[2], rda[2], rdb[2], immb[2], immalu[2];
  logic wr[2], pop[2], latch[2], busy[2], halted[2], ill[2];
  logic [15:0] icnt[2];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int   acc[2], ev_rd[2], ev_wr[2], ev_pop[2], ev_latch[2], ev_ill[2], ill_n[2];
  logic ev_rd_immb[2], ev_wr_imm[2];

  exp_t        q[2][$];
  exp_t        cur[2];
  logic [15:0] m_cnt[2];
  int          m_mode[2] = '{0, 0};

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  risc_ctrl_seq #(.ALU_LAT(LAT0), .CNT_W(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .Instr_Valid(iv[0]), .Opcode(op[0]),
    .Fetch_Req(fetch_req[0]), .Reset_AluRegs(rst_alu[0]), .Rd_Oprnd_A(rda[0]),
    .Rd_Oprnd_B(rdb[0]), .UseData_Imm_Or_RegB(immb[0]), .UseData_Imm_Or_ALU(immalu[0]),
    .Reg_Wr_En(wr[0]), .Pop_Psw(pop[0]), .Latch_Flags(latch[0]), .Busy(busy[0]),
    .Halted(halted[0]), .Illegal_Op(ill[0]), .Instr_Count(icnt[0])
  );

  risc_ctrl_seq #(.ALU_LAT(LAT1), .CNT_W(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .Instr_Valid(iv[1]), .Opcode(op[1]),
    .Fetch_Req(fetch_req[1]), .Reset_AluRegs(rst_alu[1]), .Rd_Oprnd_A(rda[1]),
    .Rd_Oprnd_B(rdb[1]), .UseData_Imm_Or_RegB(immb[1]), .UseData_Imm_Or_ALU(immalu[1]),
    .Reg_Wr_En(wr[1]), .Pop_Psw(pop[1]), .Latch_Flags(latch[1]), .Busy(busy[1]),
    .Halted(halted[1]), .Illegal_Op(ill[1]), .Instr_Count(icnt[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted instruction pushes the per-cycle strobe pattern it must produce.
  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      vec_t        act;
      exp_t        nx;
      exp_t        e;
      logic [15:0] nc;
      logic [7:0]  o;
      int          lat;
      lat = (i == 0) ? LAT0 : LAT1;
      act = {fetch_req[i], rst_alu[i], rda[i], rdb[i], immb[i], immalu[i],
             wr[i], pop[i], latch[i], busy[i], halted[i], ill[i]};
      if (m_mode[i] != 0) begin
        check($sformatf("dut%0d_strobes", i), 32'(act), 32'(cur[i].v));
        check($sformatf("dut%0d_count", i), 32'(icnt[i]), 32'(m_cnt[i]));
      end
      if (rda[i])   begin ev_rd[i] = cyc; ev_rd_immb[i] = immb[i]; end
      if (wr[i])    begin ev_wr[i] = cyc; ev_wr_imm[i] = immalu[i]; end
      if (pop[i])   ev_pop[i] = cyc;
      if (latch[i]) ev_latch[i] = cyc;
      if (ill[i])   begin ev_ill[i] = cyc; ill_n[i]++; end

      if (Reset) begin
        q[i].delete();
        cur[i] = '0;
        cur[i].v.rst_alu = 1'b1;
        m_cnt[i] = 16'd0;
        m_mode[i] = 1;
      end else if (m_mode[i] == 1) begin
        cur[i] = '0;
        cur[i].v.fetch = 1'b1;
        m_mode[i] = 2;
      end else if (m_mode[i] == 2) begin
        nc = m_cnt[i] + (cur[i].ret ? 16'd1 : 16'd0);
        nx = '0;
        nx.v.fetch = 1'b1;
        if (cur[i].v.fetch && iv[i]) begin
          o = op[i];
          if (o == 8'h08) begin
            e = '0; e.v.pop = 1'b1; e.v.busy = 1'b1; q[i].push_back(e);
            e = '0; e.v.latch = 1'b1; e.v.busy = 1'b1; e.ret = 1'b1; q[i].push_back(e);
          end else if (o == 8'h10) begin
            e = '0; e.v.wr = 1'b1; e.v.immalu = 1'b1; e.v.busy = 1'b1; e.ret = 1'b1;
            q[i].push_back(e);
          end else if (o == 8'hFF) begin
            m_mode[i] = 3;
            nc = nc + 16'd1;
            nx = '0;
            nx.v.halted = 1'b1;
          end else if (o >= 8'h40 && o < 8'hC0) begin
            e = '0; e.v.rda = 1'b1; e.v.rdb = 1'b1; e.v.immb = (o >= 8'h80); e.v.busy = 1'b1;
            q[i].push_back(e);
            for (int k = 0; k < lat; k++) begin
              e = '0; e.v.busy = 1'b1; q[i].push_back(e);
            end
            e = '0; e.v.wr = 1'b1; e.v.busy = 1'b1; e.ret = 1'b1; q[i].push_back(e);
          end else begin
            nc = nc + 16'd1;
            nx.v.ill = (o != 8'h00);
          end
        end
        if (q[i].size() > 0) nx = q[i].pop_front();
        cur[i] = nx;
        m_cnt[i] = nc;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Presents one instruction to both instances and holds it until each accepts.
  task automatic issue(input logic [7:0] opc);
    logic pend[2];
    int   n;
    pend[0] = 1'b1; pend[1] = 1'b1;
    iv[0] = 1'b1; iv[1] = 1'b1;
    op[0] = opc;  op[1] = opc;
    n = 0;
    while ((pend[0] || pend[1]) && n < 50) begin
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && fetch_req[i]) begin
          pend[i] = 1'b0;
          acc[i] = cyc;
        end
      end
      @(posedge Clk);
      #1;
      for (int i = 0; i < 2; i++) if (!pend[i]) iv[i] = 1'b0;
      n++;
    end
    if (pend[0] || pend[1]) begin
      check("accept_timeout", 32'd1, 32'd0);
      iv[0] = 1'b0; iv[1] = 1'b0;
    end
  endtask

  initial begin
    int acc_ldi, wr0, wr1, ill0, rd0;
    Reset = 1'b1;
    iv[0] = 1'b0; iv[1] = 1'b0; op[0] = 8'h00; op[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      ev_rd[i] = -1; ev_wr[i] = -1; ev_pop[i] = -1; ev_latch[i] = -1;
      ev_ill[i] = -1; ill_n[i] = 0; acc[i] = -1;
      ev_rd_immb[i] = 1'b0; ev_wr_imm[i] = 1'b0;
    end

    // Reset for two cycles, then one INIT cycle before IDLE.
    wait_cyc(2);
    Reset = 1'b0;
    #2;
    check("init_rst_alu", 32'(rst_alu[0]), 32'd1);
    check("init_fetch", 32'(fetch_req[0]), 32'd0);
    wait_cyc(1);
    check("idle_rst_alu", 32'(rst_alu[0]), 32'd0);
    check("idle_fetch", 32'(fetch_req[0]), 32'd1);
    check("idle_count", 32'(icnt[0]), 32'd0);

    // ALU reg-reg
    issue(8'h42);
    wait_cyc(6);
    check("rr_rd_lat", 32'(ev_rd[0] - acc[0]), 32'd1);
    check("rr_immb", 32'(ev_rd_immb[0]), 32'd0);
    check("rr_wr_lat_l1", 32'(ev_wr[0] - acc[0]), 32'd3);
    check("rr_immalu", 32'(ev_wr_imm[0]), 32'd0);
    check("rr_wr_lat_l3", 32'(ev_wr[1] - acc[1]), 32'd5);
    check("rr_count", 32'(icnt[0]), 32'd1);

    // ALU reg-imm8
    issue(8'h85);
    wait_cyc(6);
    check("ri_immb", 32'(ev_rd_immb[1]), 32'd1);
    check("ri_wr_lat_l3", 32'(ev_wr[1] - acc[1]), 32'd5);
    check("ri_wr_lat_l1", 32'(ev_wr[0] - acc[0]), 32'd3);
    check("ri_count", 32'(icnt[1]), 32'd2);

    // LDI then RET back-to-back
    issue(8'h10);
    acc_ldi = acc[0];
    issue(8'h08);
    wait_cyc(4);
    check("ldi_wr_lat", 32'(ev_wr[0] - acc_ldi), 32'd1);
    check("ldi_immalu", 32'(ev_wr_imm[0]), 32'd1);
    check("ldi_to_ret_accept", 32'(acc[0] - acc_ldi), 32'd2);
    check("ret_pop_lat", 32'(ev_pop[0] - acc[0]), 32'd1);
    check("ret_latch_lat", 32'(ev_latch[0] - acc[0]), 32'd2);
    check("ldi_ret_count", 32'(icnt[0]), 32'd4);

    // Illegal opcode
    ill0 = ill_n[0];
    issue(8'h3C);
    wait_cyc(2);
    check("ill_pulses", 32'(ill_n[0] - ill0), 32'd1);
    check("ill_lat", 32'(ev_ill[0] - acc[0]), 32'd1);
    check("ill_fetch", 32'(fetch_req[0]), 32'd1);
    check("ill_count", 32'(icnt[0]), 32'd5);

    // Reset during EXEC aborts the write-back
    issue(8'h42);
    wait_cyc(1);
    wr0 = ev_wr[0]; wr1 = ev_wr[1];
    Reset = 1'b1;
    wait_cyc(1);
    Reset = 1'b0;
    wait_cyc(5);
    check("abort_no_wr0", 32'(ev_wr[0]), 32'(wr0));
    check("abort_no_wr1", 32'(ev_wr[1]), 32'(wr1));
    check("abort_count", 32'(icnt[0]), 32'd0);

    // HALT ignores further valid instructions
    rd0 = ev_rd[0];
    issue(8'hFF);
    iv[0] = 1'b1; iv[1] = 1'b1; op[0] = 8'h42; op[1] = 8'h42;
    wait_cyc(5);
    check("halt_halted", 32'(halted[1]), 32'd1);
    check("halt_fetch", 32'(fetch_req[0]), 32'd0);
    check("halt_count", 32'(icnt[0]), 32'd1);
    check("halt_no_rd", 32'(ev_rd[0]), 32'(rd0));
    iv[0] = 1'b0; iv[1] = 1'b0;
    Reset = 1'b1;
    wait_cyc(1);
    Reset = 1'b0;
    check("halt_reset_init", 32'(rst_alu[0]), 32'd1);
    check("halt_reset_clear", 32'(halted[0]), 32'd0);
    wait_cyc(1);
    check("halt_reset_idle", 32'(fetch_req[0]), 32'd1);

    // Counter wrap via back-to-back NOPs
    iv[0] = 1'b1; iv[1] = 1'b1; op[0] = 8'h00; op[1] = 8'h00;
    repeat (65535) @(posedge Clk);
    #1;
    iv[0] = 1'b0; iv[1] = 1'b0;
    #2;
    check("wrap_full", 32'(icnt[0]), 32'h0000FFFF);
    issue(8'h00);
    check("wrap_zero0", 32'(icnt[0]), 32'd0);
    check("wrap_zero1", 32'(icnt[1]), 32'd0);

    wait_cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
